// File: rtl/mmio_timer_responder_if.sv
// Bus bundle for the MMIO timer responder: request/acknowledge word access
// channel between the load/store initiator and the responder.
interface mmio_timer_responder_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        bus_err;

    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_wdata,
        input  bus_rdata,
        input  bus_ack,
        input  bus_err
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_wdata,
        output bus_rdata,
        output bus_ack,
        output bus_err
    );
endinterface

// File: rtl/mmio_timer_responder.sv
// MMIO responder with configurable wait states in front of a prescaled 32-bit
// down-counter timer (auto-reload, sticky expiry flag, registered interrupt).
module mmio_timer_responder #(
    parameter logic [31:0] BASE        = 32'hFFFF_0000,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] ID_VALUE    = 32'h7143_0001
) (
    input  logic                        clk,
    input  logic                        rst,
    mmio_timer_responder_if.slave       bus,
    output logic                        irq
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    localparam logic       NO_WAIT   = (WAIT_STATES == 0);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES - 1);

    localparam logic [2:0] IDX_CTRL   = 3'd0;
    localparam logic [2:0] IDX_LOAD   = 3'd1;
    localparam logic [2:0] IDX_COUNT  = 3'd2;
    localparam logic [2:0] IDX_STATUS = 3'd3;
    localparam logic [2:0] IDX_ID     = 3'd4;

    // Byte offset relative to BASE; unsigned wrap pushes below-window
    // addresses far out of range so one compare covers both ends.
    function automatic logic [31:0] window_offset(input logic [31:0] addr);
        return addr - BASE;
    endfunction

    function automatic logic offset_in_window(input logic [31:0] off);
        return (off[31:5] == 27'd0);
    endfunction

    state_t      state_r, state_nx_s;
    logic [3:0]  wait_cnt_r, wait_cnt_nx_s;
    logic        enter_ack_s;

    logic [31:0] off_s;
    logic        in_win_s;
    logic [2:0]  reg_idx_s;
    logic        addr_lsb_unused_s;
    logic        wr_commit_s;
    logic        wr_ctrl_s;
    logic        wr_load_s;
    logic        wr_status_s;
    logic [31:0] rd_mux_s;

    logic        en_r, auto_r, irq_en_r;
    logic [7:0]  pre_r;
    logic [7:0]  pre_cnt_r;
    logic [31:0] load_r;
    logic [31:0] count_r;
    logic        expired_r;
    logic        irq_r;
    logic        ack_r, err_r;
    logic [31:0] rdata_r;

    logic        tick_s;
    logic        count_zero_s;
    logic        expire_s;

    assign bus.bus_ack   = ack_r;
    assign bus.bus_err   = err_r;
    assign bus.bus_rdata = rdata_r;
    assign irq           = irq_r;

    // Address decode and write strobes; writes commit only on the ACK-entry edge.
    always_comb begin
        off_s             = window_offset(bus.bus_addr);
        in_win_s          = offset_in_window(off_s);
        reg_idx_s         = off_s[4:2];
        addr_lsb_unused_s = ^off_s[1:0];
        wr_commit_s       = enter_ack_s & bus.bus_we & in_win_s;
        wr_ctrl_s         = wr_commit_s & (reg_idx_s == IDX_CTRL);
        wr_load_s         = wr_commit_s & (reg_idx_s == IDX_LOAD);
        wr_status_s       = wr_commit_s & (reg_idx_s == IDX_STATUS);
    end

    // Read data mux over current (pre-edge) register values.
    always_comb begin
        rd_mux_s = 32'd0;
        if (in_win_s) begin
            case (reg_idx_s)
                IDX_CTRL:   rd_mux_s = {16'd0, pre_r, 5'd0, irq_en_r, auto_r, en_r};
                IDX_LOAD:   rd_mux_s = load_r;
                IDX_COUNT:  rd_mux_s = count_r;
                IDX_STATUS: rd_mux_s = {31'd0, expired_r};
                IDX_ID:     rd_mux_s = ID_VALUE;
                default:    rd_mux_s = 32'd0;
            endcase
        end else begin
            rd_mux_s = 32'd0;
        end
    end

    // Handshake FSM next-state logic; bus_req is only looked at in IDLE.
    always_comb begin
        state_nx_s    = state_r;
        wait_cnt_nx_s = wait_cnt_r;
        enter_ack_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.bus_req) begin
                    if (NO_WAIT) begin
                        state_nx_s  = ST_ACK;
                        enter_ack_s = 1'b1;
                    end else begin
                        state_nx_s    = ST_WAIT;
                        wait_cnt_nx_s = WAIT_LOAD;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_r == 4'd0) begin
                    state_nx_s  = ST_ACK;
                    enter_ack_s = 1'b1;
                end else begin
                    wait_cnt_nx_s = wait_cnt_r - 4'd1;
                end
            end
            ST_ACK: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Handshake FSM state and wait counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= 4'd0;
        end else begin
            state_r    <= state_nx_s;
            wait_cnt_r <= wait_cnt_nx_s;
        end
    end

    // Registered response: ack/err pulse and read data held only for the ACK cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_r   <= 1'b0;
            err_r   <= 1'b0;
            rdata_r <= 32'd0;
        end else if (enter_ack_s) begin
            ack_r   <= 1'b1;
            err_r   <= ~in_win_s;
            rdata_r <= rd_mux_s;
        end else begin
            ack_r   <= 1'b0;
            err_r   <= 1'b0;
            rdata_r <= 32'd0;
        end
    end

    // Timer tick and zero detect use pre-edge EN/PRE/COUNT.
    always_comb begin
        tick_s       = en_r & (pre_cnt_r == pre_r);
        count_zero_s = (count_r == 32'd0);
        expire_s     = tick_s & count_zero_s;
    end

    // Prescaler: free-runs while enabled, wraps at PRE, parked at 0 when disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt_r <= 8'd0;
        end else if (!en_r || tick_s) begin
            pre_cnt_r <= 8'd0;
        end else begin
            pre_cnt_r <= pre_cnt_r + 8'd1;
        end
    end

    // CTRL register; a bus write takes precedence over one-shot EN auto-clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_r     <= 1'b0;
            auto_r   <= 1'b0;
            irq_en_r <= 1'b0;
            pre_r    <= 8'd0;
        end else if (wr_ctrl_s) begin
            en_r     <= bus.bus_wdata[0];
            auto_r   <= bus.bus_wdata[1];
            irq_en_r <= bus.bus_wdata[2];
            pre_r    <= bus.bus_wdata[15:8];
        end else if (expire_s && !auto_r) begin
            en_r <= 1'b0;
        end
    end

    // LOAD register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_r <= 32'd0;
        end else if (wr_load_s) begin
            load_r <= bus.bus_wdata;
        end
    end

    // COUNT: a LOAD write wins over the tick; saturates at 0 in one-shot mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= 32'd0;
        end else if (wr_load_s) begin
            count_r <= bus.bus_wdata;
        end else if (tick_s) begin
            if (!count_zero_s) begin
                count_r <= count_r - 32'd1;
            end else if (auto_r) begin
                count_r <= load_r;
            end else begin
                count_r <= 32'd0;
            end
        end
    end

    // Sticky expiry flag; a new expiry beats a simultaneous W1C.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            expired_r <= 1'b0;
        end else if (expire_s) begin
            expired_r <= 1'b1;
        end else if (wr_status_s && bus.bus_wdata[0]) begin
            expired_r <= 1'b0;
        end
    end

    // Interrupt output, registered one cycle behind expired/IRQ_EN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= expired_r & irq_en_r;
        end
    end

endmodule

// File: tb/tb_mmio_timer_responder.sv
// Scoreboard bench for mmio_timer_responder: a cycle-level behavioural model
// predicts every ack, a monitor compares, plus directed scenario checks.
module tb_mmio_timer_responder;

    localparam logic [31:0] BASE = 32'hFFFF_0000;
    localparam int          WS   = 1;
    localparam logic [31:0] ID   = 32'h7143_0001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic irq, irq0;

    always #5 clk = ~clk;

    mmio_timer_responder_if bif ();
    mmio_timer_responder_if bif0 ();

    mmio_timer_responder #(.BASE(BASE), .WAIT_STATES(WS), .ID_VALUE(ID)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bif),
        .irq (irq)
    );

    mmio_timer_responder #(.BASE(BASE), .WAIT_STATES(0), .ID_VALUE(ID)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bif0),
        .irq (irq0)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        is_read;
    } exp_t;
    exp_t exp_q[$];

    // Reference model state.
    logic        m_en, m_auto, m_irq_en, m_expired, m_irq;
    logic [7:0]  m_pre, m_psc;
    logic [31:0] m_load, m_count;
    int          m_cyc, m_acc, m_done;
    logic        m_busy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        if (off >= 32'd32) return 32'd0;
        case (off[4:2])
            3'd0:    return {16'd0, m_pre, 5'd0, m_irq_en, m_auto, m_en};
            3'd1:    return m_load;
            3'd2:    return m_count;
            3'd3:    return {31'd0, m_expired};
            3'd4:    return ID;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_en = 1'b0; m_auto = 1'b0; m_irq_en = 1'b0; m_expired = 1'b0; m_irq = 1'b0;
        m_pre = 8'd0; m_psc = 8'd0; m_load = 32'd0; m_count = 32'd0;
        m_cyc = 0; m_acc = 0; m_done = 0; m_busy = 1'b0;
        exp_q.delete();
    endtask

    // One clock edge of the timer, optionally with a committing bus access.
    task automatic model_edge(input logic commit, input logic we,
                              input logic [31:0] addr, input logic [31:0] w);
        logic        tick, zero, n_en, n_auto, n_irq_en, n_exp;
        logic [7:0]  n_pre, n_psc;
        logic [31:0] n_load, n_count, off;
        exp_t        e;
        tick = m_en && (m_psc == m_pre);
        zero = (m_count == 32'd0);
        n_en = m_en; n_auto = m_auto; n_irq_en = m_irq_en; n_exp = m_expired;
        n_pre = m_pre; n_load = m_load; n_count = m_count;
        n_psc = (!m_en || tick) ? 8'd0 : m_psc + 8'd1;
        if (tick) begin
            if (!zero) n_count = m_count - 32'd1;
            else begin
                n_exp = 1'b1;
                if (m_auto) n_count = m_load;
                else n_en = 1'b0;
            end
        end
        if (commit) begin
            off = addr - BASE;
            e.rdata = model_read(addr);
            e.err = (off >= 32'd32);
            e.is_read = !we;
            exp_q.push_back(e);
            if (we && off < 32'd32) begin
                case (off[4:2])
                    3'd0: begin n_en = w[0]; n_auto = w[1]; n_irq_en = w[2]; n_pre = w[15:8]; end
                    3'd1: begin n_load = w; n_count = w; end
                    3'd3: if (w[0] && !(tick && zero)) n_exp = 1'b0;
                    default: ;
                endcase
            end
        end
        m_irq = m_expired & m_irq_en;
        m_en = n_en; m_auto = n_auto; m_irq_en = n_irq_en; m_expired = n_exp;
        m_pre = n_pre; m_psc = n_psc; m_load = n_load; m_count = n_count;
    endtask

    // Model process: request acceptance and commit edge from the access latency.
    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else begin
                m_cyc++;
                if (m_busy && m_cyc == m_done) m_busy = 1'b0;
                else if (!m_busy && bif.bus_req) begin
                    m_busy = 1'b1; m_acc = m_cyc; m_done = m_cyc + WS + 1;
                end
                model_edge(m_busy && (m_cyc == m_acc + WS), bif.bus_we, bif.bus_addr, bif.bus_wdata);
            end
        end
    end

    // Monitor: compare acks against the scoreboard and idle outputs against 0.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("irq", {31'd0, irq}, {31'd0, m_irq});
                if (bif.bus_ack) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_ack: got ack=1 expected no ack at %0t", $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("ack_err", {31'd0, bif.bus_err}, {31'd0, e.err});
                        if (e.is_read) check("ack_rdata", bif.bus_rdata, e.rdata);
                    end
                end else begin
                    check("idle_rdata_err", {bif.bus_rdata[31:1], bif.bus_rdata[0] | bif.bus_err}, 32'd0);
                end
            end
        end
    end

    task automatic bus_xfer(input logic we, input logic [31:0] addr, input logic [31:0] w,
                            output logic [31:0] rdata, output logic err, output int lat);
        logic got;
        got = 1'b0; rdata = 32'd0; err = 1'b0; lat = 0;
        @(negedge clk);
        bif.bus_req = 1'b1; bif.bus_we = we; bif.bus_addr = addr; bif.bus_wdata = w;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (bif.bus_ack) begin
                got = 1'b1; rdata = bif.bus_rdata; err = bif.bus_err;
            end
        end
        bif.bus_req = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL ack_timeout: got no ack expected ack within 40 cycles addr %h", addr);
        end
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] w);
        logic [31:0] r; logic e; int l;
        bus_xfer(1'b1, addr, w, r, e, l);
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] r);
        logic e; int l;
        bus_xfer(1'b0, addr, 32'd0, r, e, l);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r, w, c0, a;
        logic        e;
        int          lat, acks;
        logic [31:0] oow [3];
        oow[0] = 32'h0000_1000; oow[1] = 32'hFFFF_0020; oow[2] = 32'hFFFE_FFFC;

        bif.bus_req = 1'b0; bif.bus_we = 1'b0; bif.bus_addr = 32'd0; bif.bus_wdata = 32'd0;
        bif0.bus_req = 1'b0; bif0.bus_we = 1'b0; bif0.bus_addr = 32'd0; bif0.bus_wdata = 32'd0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ack", {31'd0, bif.bus_ack}, 32'd0);
        check("rst_err", {31'd0, bif.bus_err}, 32'd0);
        check("rst_rdata", bif.bus_rdata, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        rst = 1'b0;

        // ID read and latency.
        bus_xfer(1'b0, BASE + 32'h10, 32'd0, r, e, lat);
        check("id_rdata", r, ID);
        check("id_err", {31'd0, e}, 32'd0);
        check("id_latency", 32'(lat), 32'(WS + 1));
        rd(BASE, r);
        check("ctrl_reset", r, 32'd0);

        // One-shot countdown from 3.
        wr(BASE + 32'h04, 32'd3);
        wr(BASE + 32'h00, 32'h0000_0005);
        repeat (12) @(negedge clk);
        rd(BASE + 32'h00, r);
        check("oneshot_en_cleared", r, 32'h0000_0004);
        rd(BASE + 32'h08, r);
        check("oneshot_count_zero", r, 32'd0);
        rd(BASE + 32'h0C, r);
        check("oneshot_expired", r, 32'd1);
        check("oneshot_irq", {31'd0, irq}, 32'd1);

        // Auto-reload with PRE = 2; the scoreboard tracks every sampled value.
        wr(BASE + 32'h0C, 32'd1);
        wr(BASE + 32'h04, 32'd2);
        wr(BASE + 32'h00, 32'h0000_0203);
        for (int i = 0; i < 12; i++) begin
            rd(BASE + ((i % 2 == 0) ? 32'h08 : 32'h0C), r);
        end

        // W1C on the same edge as an expiry (LOAD 0 + AUTO expires every tick).
        wr(BASE + 32'h04, 32'd0);
        wr(BASE + 32'h00, 32'h0000_0007);
        wr(BASE + 32'h0C, 32'd1);
        rd(BASE + 32'h0C, r);
        check("w1c_set_wins", r, 32'd1);
        wr(BASE + 32'h00, 32'h0000_0004);
        repeat (3) @(negedge clk);
        check("irq_before_clear", {31'd0, irq}, 32'd1);
        wr(BASE + 32'h0C, 32'd1);
        rd(BASE + 32'h0C, r);
        check("w1c_cleared", r, 32'd0);
        check("irq_dropped", {31'd0, irq}, 32'd0);

        // Out-of-window access and read-only COUNT.
        bus_xfer(1'b0, 32'h0000_1000, 32'd0, r, e, lat);
        check("oow_err", {31'd0, e}, 32'd1);
        check("oow_rdata", r, 32'd0);
        rd(BASE + 32'h08, c0);
        wr(BASE + 32'h08, 32'h0000_1234);
        rd(BASE + 32'h08, r);
        check("count_ro", r, c0);

        // Randomized traffic against the model.
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 9) == 0) a = oow[$urandom_range(0, 2)];
            else a = BASE + {27'd0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            w = $urandom;
            case (a[4:2])
                3'd0: w[15:8] = 8'($urandom_range(0, 3));
                3'd1: w = 32'($urandom_range(0, 10));
                default: ;
            endcase
            bus_xfer(1'($urandom_range(0, 1)), a, w, r, e, lat);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Back-to-back reads on the zero-wait instance with bus_req held high.
        acks = 0;
        @(negedge clk);
        bif0.bus_req = 1'b1; bif0.bus_we = 1'b0; bif0.bus_addr = BASE + 32'h10;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bif0.bus_ack) begin
                acks++;
                check("ws0_rdata", bif0.bus_rdata, ID);
            end
        end
        bif0.bus_req = 1'b0;
        check("ws0_ack_count", 32'(acks), 32'd10);

        // Reset during WAIT aborts a LOAD write.
        wr(BASE + 32'h04, 32'd0);
        wr(BASE + 32'h00, 32'h0000_0005);
        repeat (4) @(negedge clk);
        check("irq_before_rst", {31'd0, irq}, 32'd1);
        @(negedge clk);
        bif.bus_req = 1'b1; bif.bus_we = 1'b1; bif.bus_addr = BASE + 32'h04; bif.bus_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        #2;
        rst = 1'b1;
        bif.bus_req = 1'b0;
        #1;
        check("rst_mid_ack", {31'd0, bif.bus_ack}, 32'd0);
        check("rst_mid_outputs", bif.bus_rdata | {30'd0, bif.bus_err, irq}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        rd(BASE + 32'h04, r);
        check("rst_load_dropped", r, 32'd0);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
